// File: rtl/fp_add_sub.sv
// IEEE-754 binary floating-point adder/subtractor, round-to-nearest-even with full special-value handling.
// Combinational datapath feeding one result register: latency 1 cycle, one operation per cycle.
module fp_add_sub #(
    parameter int WIDTH  = 32,
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             operation_select,
    output logic [WIDTH-1:0] result
);
    // Working significand: hidden bit, fraction, then guard/round/sticky.
    localparam int               SIG_W    = MANT_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W:0]   E1_ONE   = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] SIG_W_E  = EXP_W'(SIG_W);
    localparam logic [WIDTH-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

    logic                    sa, sb;
    logic [EXP_W-1:0]        ea, eb;
    logic [MANT_W-1:0]       fa, fb;
    logic [WIDTH-1:0]        b_adj;
    logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    logic                    a_big, s_big, s_small, found, rnd;
    logic [EXP_W-1:0]        e_big, e_small, diff;
    logic [SIG_W-1:0]        sig_big, sig_small, small_al, norm;
    logic [2*SIG_W-1:0]      shifted;
    logic [SIG_W:0]          sum;
    logic [EXP_W:0]          lz, shamt, e_big_w, norm_exp;
    logic [EXP_W+MANT_W-1:0] mag_bits, rounded;
    logic [WIDTH-1:0]        fin_res, nxt;

    // Subtraction is addition with b's sign flipped, applied before any classification.
    assign sa    = a[WIDTH-1];
    assign ea    = a[WIDTH-2:MANT_W];
    assign fa    = a[MANT_W-1:0];
    assign sb    = b[WIDTH-1] ^ operation_select;
    assign eb    = b[WIDTH-2:MANT_W];
    assign fb    = b[MANT_W-1:0];
    assign b_adj = {sb, eb, fb};

    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);

    always_comb begin
        // Magnitude order: the raw {exp, frac} fields compare like unsigned integers.
        a_big     = {ea, fa} >= {eb, fb};
        s_big     = a_big ? sa : sb;
        s_small   = a_big ? sb : sa;
        e_big     = a_big ? ea : eb;
        e_small   = a_big ? eb : ea;
        sig_big   = a_big ? {|ea, fa, 3'b000} : {|eb, fb, 3'b000};
        sig_small = a_big ? {|eb, fb, 3'b000} : {|ea, fa, 3'b000};
        if (e_big == '0)   e_big   = EXP_ONE;
        if (e_small == '0) e_small = EXP_ONE;

        diff     = e_big - e_small;
        shifted  = (diff >= SIG_W_E) ? {{SIG_W{1'b0}}, sig_small}
                                     : ({sig_small, {SIG_W{1'b0}}} >> diff);
        small_al = {shifted[2*SIG_W-1:SIG_W+1], shifted[SIG_W] | (|shifted[SIG_W-1:0])};
        sum      = (s_big == s_small) ? {1'b0, sig_big} + {1'b0, small_al}
                                      : {1'b0, sig_big} - {1'b0, small_al};

        // NOTE: blocking assignments here model combinational ripple; the loop unrolls to a priority encoder.
        lz    = '0;
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lz    = lz + E1_ONE;
            end
        end
        e_big_w = {1'b0, e_big};
        shamt   = (lz < e_big_w - E1_ONE) ? lz : e_big_w - E1_ONE;

        if (sum[SIG_W]) begin
            norm     = sum[SIG_W:1];
            norm[0]  = sum[1] | sum[0];
            norm_exp = e_big_w + E1_ONE;
        end else begin
            norm     = sum[SIG_W-1:0] << shamt;
            norm_exp = e_big_w - shamt;
        end

        // Adding the round bit to {exp, frac} lets carries renormalise and promote subnormals.
        rnd      = norm[2] & (norm[1] | norm[0] | norm[3]);
        mag_bits = {(norm[SIG_W-1] ? norm_exp[EXP_W-1:0] : {EXP_W{1'b0}}), norm[SIG_W-2:3]};
        rounded  = mag_bits + {{(EXP_W+MANT_W-1){1'b0}}, rnd};
        if ((norm_exp >= {1'b0, EXP_ONES}) || (rounded[EXP_W+MANT_W-1:MANT_W] == EXP_ONES))
            fin_res = {s_big, EXP_ONES, {MANT_W{1'b0}}};
        else
            fin_res = {s_big, rounded};

        nxt = fin_res;
        if (a_nan || b_nan)        nxt = QNAN;
        else if (a_inf && b_inf)   nxt = (sa != sb) ? QNAN : {sa, EXP_ONES, {MANT_W{1'b0}}};
        else if (a_inf)            nxt = a;
        else if (b_inf)            nxt = b_adj;
        else if (a_zero && b_zero) nxt = (sa == sb) ? {sa, {(WIDTH-1){1'b0}}} : '0;
        else if (a_zero)           nxt = b_adj;
        else if (b_zero)           nxt = a;
        else if (sum == '0)        nxt = '0;
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset forces +0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result <= '0;
        else        result <= nxt;
    end

endmodule

// File: tb/tb_fp_add_sub.sv
// Self-checking bench for fp_add_sub: directed vector table, reset sequences and randomised
// back-to-back traffic compared against an exact-integer IEEE binary32 reference model.
module tb_fp_add_sub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b, result;
    logic        operation_select;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] ra, rb, expv;

    fp_add_sub #(.WIDTH(32), .EXP_W(8), .MANT_W(23)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .a                (a),
        .b                (b),
        .operation_select (operation_select),
        .result           (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic apply(input logic op, input logic [31:0] x, input logic [31:0] y);
        operation_select = op;
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    // Exact value of a finite operand in units of 2^-149 (smallest subnormal).
    function automatic logic [299:0] mag(input logic [31:0] x);
        logic [299:0] sig;
        int           e;
        sig = {276'b0, (x[30:23] != 8'h00), x[22:0]};
        e   = (x[30:23] == 8'h00) ? 1 : int'(x[30:23]);
        return sig << (e - 1);
    endfunction

    // Reference: exact signed sum of the two values, then one IEEE RNE rounding to binary32.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] yin, input logic op);
        logic [31:0]  y;
        logic [299:0] mx, my, m, one, mask, rem, half, q;
        logic         xn, yn, xi, yi, xz, yz, sr;
        int           p, sh, e;
        y  = {yin[31] ^ op, yin[30:0]};
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xz = (x[30:0] == 0);
        yz = (y[30:0] == 0);
        if (xn || yn) return 32'h7FC00000;
        if (xi && yi) return (x[31] != y[31]) ? 32'h7FC00000 : x;
        if (xi) return x;
        if (yi) return y;
        if (xz && yz) return (x[31] == y[31]) ? x : 32'h0;
        if (xz) return y;
        if (yz) return x;
        mx = mag(x);
        my = mag(y);
        if (x[31] == y[31]) begin
            m = mx + my; sr = x[31];
        end else if (mx >= my) begin
            m = mx - my; sr = x[31];
        end else begin
            m = my - mx; sr = y[31];
        end
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 299; i >= 0; i--) begin
            if (m[i]) begin
                p = i;
                break;
            end
        end
        if (p <= 23) return {sr, m[30:0]};
        sh   = p - 23;
        e    = p - 22;
        one  = 1;
        mask = (one << sh) - one;
        rem  = m & mask;
        half = one << (sh - 1);
        q    = m >> sh;
        if ((rem > half) || ((rem == half) && q[0])) q = q + one;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {sr, 8'hFF, 23'h0};
        return {sr, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_mag();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 15))
            0:       e = 8'h00;
            1:       begin e = 8'h00; f = 23'($urandom_range(0, 3)); end
            2:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'h0; end
            3:       e = 8'hFE;
            4:       e = 8'h01;
            5:       e = 8'($urandom);
            default: e = 8'($urandom_range(110, 145));
        endcase
        return {1'b0, e, f};
    endfunction

    initial begin
        vecs.push_back('{"add_cancel",     1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000});
        vecs.push_back('{"sub_basic",      1'b1, 32'h40400000, 32'h3F800000, 32'h40000000});
        vecs.push_back('{"add_negatives",  1'b0, 32'hC0000000, 32'hBF800000, 32'hC0400000});
        vecs.push_back('{"nan_in",         1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000});
        vecs.push_back('{"nan_in_b_sub",   1'b1, 32'h3F800000, 32'hFFC00001, 32'h7FC00000});
        vecs.push_back('{"inf_minus_inf",  1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000});
        vecs.push_back('{"inf_plus_fin",   1'b0, 32'h7F800000, 32'h42280000, 32'h7F800000});
        vecs.push_back('{"ninf_sub_ninf",  1'b1, 32'hFF800000, 32'hFF800000, 32'h7FC00000});
        vecs.push_back('{"nzero_add",      1'b0, 32'h80000000, 32'h80000000, 32'h80000000});
        vecs.push_back('{"nzero_sub_pz",   1'b1, 32'h80000000, 32'h00000000, 32'h80000000});
        vecs.push_back('{"pzero_sub_pz",   1'b1, 32'h00000000, 32'h00000000, 32'h00000000});
        vecs.push_back('{"zero_plus_sub",  1'b0, 32'h00000000, 32'h00000001, 32'h00000001});
        vecs.push_back('{"max_overflow",   1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000});
        vecs.push_back('{"nmax_overflow",  1'b1, 32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000});
        vecs.push_back('{"tie_even",       1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000});
        vecs.push_back('{"tie_odd",        1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002});
        vecs.push_back('{"norm_to_subn",   1'b1, 32'h00800000, 32'h00000001, 32'h007FFFFF});
        vecs.push_back('{"subn_to_normal", 1'b0, 32'h00400000, 32'h00400000, 32'h00800000});

        rst_n            = 1'b0;
        operation_select = 1'b0;
        a                = 32'h3F800000;
        b                = 32'h40000000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", result, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", result, 32'h40400000);

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check(vecs[i].name, result, vecs[i].exp);
        end

        // Mid-stream asynchronous reset, then resume without stale data.
        apply(1'b0, 32'h3F800000, 32'h3F800000);
        check("pre_midreset", result, 32'h40000000);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async_clear", result, 32'h00000000);
        operation_select = 1'b1;
        a                = 32'h40400000;
        b                = 32'h3F800000;
        @(posedge clk);
        #1;
        check("midreset_held", result, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_midreset", result, 32'h40000000);

        // Randomised back-to-back traffic per op and effective-sign class.
        for (int op = 0; op < 2; op++) begin
            for (int d = 0; d < 2; d++) begin
                for (int n = 0; n < 10000; n++) begin
                    ra = rand_mag();
                    rb = rand_mag();
                    case ($urandom_range(0, 3))
                        0:       rb = ra ^ (32'h1 << $urandom_range(0, 4));
                        1:       rb[30:23] = ra[30:23] - 8'($urandom_range(0, 2));
                        default: ;
                    endcase
                    ra[31] = 1'($urandom);
                    rb[31] = ra[31] ^ 1'(d) ^ 1'(op);
                    expv   = model(ra, rb, 1'(op));
                    apply(1'(op), ra, rb);
                    if (result !== expv)
                        check($sformatf("rand op=%0d a=%h b=%h", op, ra, rb), result, expv);
                    else
                        check("rand", result, expv);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
